// File: rtl/mpu_result_collector.sv
// mpu_result_collector: gathers the MPU scalar result stream into a row-major
// MAT_ROWS x MAT_COLS buffer, then replays it with row/col tags over a second
// stb/ack handshake. matrix_done pulses when the last element is taken.
// FILL and DRAIN never overlap. Every output is registered.
module mpu_result_collector #(
  parameter int MAT_ROWS   = 3,
  parameter int MAT_COLS   = 3,
  parameter int DATA_WIDTH = 32,
  localparam int ROW_W     = (MAT_ROWS > 1) ? $clog2(MAT_ROWS) : 1,
  localparam int COL_W     = (MAT_COLS > 1) ? $clog2(MAT_COLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] output_z,
  input  logic                  output_stb,
  output logic                  output_ack,
  output logic [DATA_WIDTH-1:0] result_z,
  output logic [ROW_W-1:0]      result_row,
  output logic [COL_W-1:0]      result_col,
  output logic                  result_stb,
  input  logic                  result_ack,
  output logic                  matrix_done
);

  localparam int TOTAL = MAT_ROWS * MAT_COLS;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAT_COLS - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        wr_idx;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        nxt_rd;
  logic [DATA_WIDTH-1:0]   mem [TOTAL];
  logic                    in_xfer;
  logic                    out_xfer;

  assign in_xfer  = output_stb && output_ack;
  assign out_xfer = result_stb && result_ack;
  assign nxt_rd   = rd_idx + IDX_W'(1);

  // Element storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && in_xfer)
      mem[wr_idx] <= output_z;
  end

  // FILL/DRAIN control with registered handshake and replay outputs.
  // Row/col are kept as counters alongside rd_idx instead of dividing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      wr_idx      <= '0;
      rd_idx      <= '0;
      output_ack  <= 1'b0;
      result_stb  <= 1'b0;
      result_z    <= '0;
      result_row  <= '0;
      result_col  <= '0;
      matrix_done <= 1'b0;
    end else begin
      matrix_done <= 1'b0;
      case (state)
        FILL: begin
          output_ack <= 1'b1;
          if (in_xfer) begin
            if (wr_idx == IDX_LAST) begin
              output_ack <= 1'b0;
              state      <= DRAIN;
              wr_idx     <= '0;
              rd_idx     <= '0;
              result_stb <= 1'b1;
              // With a single element the buffer write lands this same edge.
              result_z   <= (TOTAL == 1) ? output_z : mem[0];
              result_row <= '0;
              result_col <= '0;
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            if (rd_idx == IDX_LAST) begin
              result_stb  <= 1'b0;
              matrix_done <= 1'b1;
              state       <= FILL;
              output_ack  <= 1'b1;
              rd_idx      <= '0;
            end else begin
              rd_idx   <= nxt_rd;
              result_z <= mem[nxt_rd];
              if (result_col == COL_LAST) begin
                result_col <= '0;
                result_row <= result_row + ROW_W'(1);
              end else begin
                result_col <= result_col + COL_W'(1);
              end
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/mpu_result_collector.md
# mpu_result_collector

Downstream stage of the matrix processing unit (MPU). Accepts the MPU's scalar result stream (`output_z` / `output_stb` / `output_ack`) and stores the elements row-major into an internal MAT_ROWS x MAT_COLS buffer. Once the matrix is complete, it replays the matrix over a second stb/ack handshake, tagged with row and column indices, and pulses `matrix_done`. It then re-arms for the next matrix.

## Interface
- MAT_ROWS, 3: result matrix rows (>=1)
- MAT_COLS, 3: result matrix columns (>=1)
- DATA_WIDTH, 32: element width; matches the MPU `int` result
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- output_z  in  DATA_WIDTH  result element from MPU
- output_stb  in  1  MPU result valid
- output_ack  out  1  collector ready; registered
- result_z  out  DATA_WIDTH  replayed element; registered
- result_row  out  $clog2(MAT_ROWS) (min 1)  row index of result_z
- result_col  out  $clog2(MAT_COLS) (min 1)  column index of result_z
- result_stb  out  1  result_z valid; registered
- result_ack  in  1  downstream ready
- matrix_done  out  1  one-cycle pulse; last element of the matrix was taken downstream

## Operation
- TOTAL = MAT_ROWS*MAT_COLS.
- Index width is $clog2(TOTAL), minimum 1.
- Transfer rule for both interfaces: a transfer happens on a rising edge where stb && ack are both high. Elements are stored and replayed bit-exact, with no arithmetic.
- States are FILL and DRAIN.
- Reset (rst high at an edge):
  - state=FILL, wr_idx=0, rd_idx=0.
  - output_ack=0, result_stb=0, result_z=0, result_row=0, result_col=0, matrix_done=0.
  - Buffer contents are don't-care.
- FILL:
  - output_ack is registered high from the first edge after rst deasserts.
  - Each transfer writes output_z to buf[wr_idx] and increments wr_idx.
  - On the transfer with wr_idx==TOTAL-1, the same edge sets:
    - output_ack<=0, state<=DRAIN, rd_idx<=0, wr_idx<=0.
    - result_stb<=1, result_z<=buf[0], result_row<=0, result_col<=0.
    - If TOTAL==1, result_z<=output_z (write-through).
- DRAIN:
  - output_ack stays 0; output_stb is ignored, and data held by the MPU waits.
  - Each result transfer increments rd_idx. result_z/row/col load the next element (row = idx / MAT_COLS, col = idx % MAT_COLS) at the same edge, so result_stb can stay high for one element per cycle.
  - While result_ack is low, result_z, result_row, result_col and result_stb hold stable.
  - On the transfer with rd_idx==TOTAL-1, the same edge sets:
    - result_stb<=0, matrix_done<=1 (for one cycle), state<=FILL, output_ack<=1.
- Indices wrap to 0 at TOTAL; no partial-matrix drain.
- Reset mid-FILL or mid-DRAIN discards the partial matrix with no `matrix_done`, and resumes FILL after rst deasserts.
- rst has priority over any simultaneous transfer.

## Timing
- Fill throughput: one element per cycle, given output_stb held high.
- The first result_stb is high in the cycle after the final FILL transfer edge.
- The first new output_ack is high in the cycle after the final DRAIN transfer edge. That is the same cycle matrix_done is high.
- There is no overlap between FILL and DRAIN, so a minimum of 2*TOTAL cycles per matrix.
- No combinational path exists from any input to any output.

## Test plan
- **Reset values:** assert rst 10 cycles, then release. All outputs read 0 during reset. output_ack=1 on the first cycle after release; result_stb=0.
- **Back-to-back 2x2:** with MAT_ROWS=MAT_COLS=2, stream 0x1,0x2,0x3,0x4 with output_stb always high and result_ack=1.
  - Expect result_z 0x1,0x2,0x3,0x4 on consecutive cycles.
  - Expect (row,col) = (0,0),(0,1),(1,0),(1,1).
  - Expect matrix_done for one cycle after 0x4, then output_ack=1.
- **Backpressure:** in the 3x3 default, hold result_ack low for 5 cycles mid-drain. result_z, indices and result_stb stay frozen; no element is lost or duplicated across 9 outputs.
- **Gaps and blocking:** output_stb gaps during FILL are ignored and the buffer is filled correctly. A value (0xDEAD) offered during DRAIN gets output_ack=0 until re-arm, then lands at position (0,0) of the next matrix.
- **Reset mid-operation:** assert rst after 5 of 9 fills, then stream 9 fresh values 0x10..0x18. Exactly 0x10..0x18 drain, with no stale data and one matrix_done.
- **Repeat:** run 3 consecutive 3x3 matrices with random result_ack. Expect exactly 3 matrix_done pulses and row-major order every time.
